// File: rtl/pixel_fetcher.sv
// Pixel fetcher: after a start edge, reads the pixel words from the register file and streams
// them one pixel at a time, LSB pixel first. Define PIXEL_FETCHER_PREFETCH_EN to add a spare word buffer.
module pixel_fetcher #(
    parameter int Amba_Word       = 24,
    parameter int Amba_Addr_Depth = 13,
    parameter int Pixel_Width     = 8,
    parameter int Base_Addr       = 1,
    parameter int Num_Words       = 4096
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [Amba_Word-1:0]     Start_work_reg,
    output logic [1:0]               control,
    output logic [Amba_Addr_Depth:0] address,
    input  logic [Amba_Word-1:0]     ReadData,
    output logic [Pixel_Width-1:0]   pix_data,
    output logic                     pix_valid,
    input  logic                     pix_ready,
    output logic                     pix_last,
    output logic                     busy,
    output logic                     done
);

    // state   | meaning
    // IDLE    | waiting for a rising edge of the start flag
    // REQ     | read command on control/address for one cycle
    // CAPTURE | read data arrives; latched into the unpack register
    // DRAIN   | presenting pixels of the current word
    // DONE    | one-cycle done pulse, then back to IDLE
    typedef enum logic [2:0] {IDLE, REQ, CAPTURE, DRAIN, DONE} state_t;

    localparam int PPW = Amba_Word / Pixel_Width;
    localparam int AW  = Amba_Addr_Depth + 1;
    localparam int IW  = (PPW > 1) ? $clog2(PPW) : 1;

    localparam logic [AW-1:0] BASE      = AW'(Base_Addr);
    localparam logic [AW-1:0] LAST_WORD = AW'(Num_Words - 1);
    localparam logic [AW-1:0] ONE       = AW'(1);
    localparam logic [IW-1:0] LAST_PIX  = IW'(PPW - 1);
    localparam logic [IW-1:0] ONE_IX    = IW'(1);
    localparam logic [1:0]    CMD_READ  = 2'b10;
    localparam logic [1:0]    CMD_IDLE  = 2'b00;

    state_t                state;
    logic                  start_prev;
    logic [AW-1:0]         word_idx;
    logic [IW-1:0]         pix_idx;
    logic [Amba_Word-1:0]  word_buf;
    logic                  start_edge;
    logic                  abort;
    logic                  xfer;
    logic                  unused_start_bits;

    assign start_edge        = Start_work_reg[0] & ~start_prev;
    assign abort             = ~Start_work_reg[0] & (state != IDLE) & (state != DONE);
    assign xfer              = pix_valid & pix_ready;
    assign unused_start_bits = ^Start_work_reg[Amba_Word-1:1];

    function automatic logic [Pixel_Width-1:0] pick(input logic [Amba_Word-1:0] w,
                                                    input logic [IW-1:0] i);
        logic [Amba_Word-1:0] sh;
        sh = w >> (int'(i) * Pixel_Width);
        return sh[Pixel_Width-1:0];
    endfunction

`ifdef PIXEL_FETCHER_PREFETCH_EN
    logic [Amba_Word-1:0] spare;
    logic                 spare_valid;
    logic                 cap_pend;
    logic [Amba_Word-1:0] next_word;

    // A prefetch whose data lands in the same cycle as the swap is taken straight from ReadData.
    always_comb begin
        next_word = ReadData;
        if (spare_valid) next_word = spare;
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            start_prev  <= 1'b0;
            word_idx    <= '0;
            pix_idx     <= '0;
            word_buf    <= '0;
            control     <= CMD_IDLE;
            address     <= '0;
            pix_data    <= '0;
            pix_valid   <= 1'b0;
            pix_last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef PIXEL_FETCHER_PREFETCH_EN
            spare       <= '0;
            spare_valid <= 1'b0;
            cap_pend    <= 1'b0;
`endif
        end else begin
            start_prev <= Start_work_reg[0];
            if (abort) begin
                state     <= IDLE;
                control   <= CMD_IDLE;
                address   <= '0;
                pix_valid <= 1'b0;
                pix_last  <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b0;
`ifdef PIXEL_FETCHER_PREFETCH_EN
                spare_valid <= 1'b0;
                cap_pend    <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        done <= 1'b0;
                        if (start_edge) begin
                            state    <= REQ;
                            busy     <= 1'b1;
                            word_idx <= '0;
                            control  <= CMD_READ;
                            address  <= BASE;
                        end
                    end
                    REQ: begin
                        control <= CMD_IDLE;
                        state   <= CAPTURE;
                    end
                    CAPTURE: begin
                        word_buf  <= ReadData;
                        pix_idx   <= '0;
                        pix_data  <= pick(ReadData, '0);
                        pix_valid <= 1'b1;
                        pix_last  <= (word_idx == LAST_WORD) && (PPW == 1);
                        state     <= DRAIN;
`ifdef PIXEL_FETCHER_PREFETCH_EN
                        spare_valid <= 1'b0;
                        cap_pend    <= 1'b0;
                        if (word_idx != LAST_WORD) begin
                            control <= CMD_READ;
                            address <= BASE + word_idx + ONE;
                        end
`endif
                    end
                    DRAIN: begin
`ifdef PIXEL_FETCHER_PREFETCH_EN
                        control  <= CMD_IDLE;
                        cap_pend <= (control == CMD_READ);
                        if (cap_pend) begin
                            spare       <= ReadData;
                            spare_valid <= 1'b1;
                        end
`endif
                        if (xfer) begin
                            if (pix_idx != LAST_PIX) begin
                                pix_idx  <= pix_idx + ONE_IX;
                                pix_data <= pick(word_buf, pix_idx + ONE_IX);
                                pix_last <= (word_idx == LAST_WORD) && (pix_idx + ONE_IX == LAST_PIX);
                            end else if (word_idx == LAST_WORD) begin
                                state     <= DONE;
                                pix_valid <= 1'b0;
                                pix_last  <= 1'b0;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                            end else begin
`ifdef PIXEL_FETCHER_PREFETCH_EN
                                if (spare_valid || cap_pend) begin
                                    word_buf    <= next_word;
                                    word_idx    <= word_idx + ONE;
                                    pix_idx     <= '0;
                                    pix_data    <= pick(next_word, '0);
                                    pix_last    <= (word_idx + ONE == LAST_WORD) && (PPW == 1);
                                    spare_valid <= 1'b0;
                                    cap_pend    <= 1'b0;
                                    if (word_idx + ONE != LAST_WORD) begin
                                        control <= CMD_READ;
                                        address <= BASE + word_idx + ONE + ONE;
                                    end
                                end else if (control == CMD_READ) begin
                                    state     <= CAPTURE;
                                    word_idx  <= word_idx + ONE;
                                    pix_valid <= 1'b0;
                                    pix_last  <= 1'b0;
                                    cap_pend  <= 1'b0;
                                end else begin
                                    state     <= REQ;
                                    word_idx  <= word_idx + ONE;
                                    control   <= CMD_READ;
                                    address   <= BASE + word_idx + ONE;
                                    pix_valid <= 1'b0;
                                    pix_last  <= 1'b0;
                                end
`else
                                state     <= REQ;
                                word_idx  <= word_idx + ONE;
                                control   <= CMD_READ;
                                address   <= BASE + word_idx + ONE;
                                pix_valid <= 1'b0;
                                pix_last  <= 1'b0;
`endif
                            end
                        end
                    end
                    DONE: begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pixel_fetcher.sv
// Bench for pixel_fetcher: register-file responder, a stream-level reference model with a
// per-cycle compare process, and directed scenarios with literal expectations.
module tb_pixel_fetcher;

    localparam int WW    = 24;
    localparam int AD    = 13;
    localparam int PW    = 8;
    localparam int BASE  = 1;
    localparam int NW    = 2;
    localparam int PPW   = WW / PW;
    localparam int TOTAL = NW * PPW;

    logic          clock = 1'b0;
    logic          reset;
    logic [WW-1:0] Start_work_reg;
    logic [1:0]    control;
    logic [AD:0]   address;
    logic [WW-1:0] ReadData;
    logic [PW-1:0] pix_data;
    logic          pix_valid;
    logic          pix_ready;
    logic          pix_last;
    logic          busy;
    logic          done;

    pixel_fetcher #(
        .Amba_Word(WW), .Amba_Addr_Depth(AD), .Pixel_Width(PW),
        .Base_Addr(BASE), .Num_Words(NW)
    ) dut (
        .clock(clock), .reset(reset), .Start_work_reg(Start_work_reg),
        .control(control), .address(address), .ReadData(ReadData),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_last(pix_last), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    logic [WW-1:0] mem [0:15];

    // Register file: data for a read command is valid the following cycle; junk otherwise.
    always @(posedge clock)
        ReadData <= (control == 2'b10) ? mem[address[3:0]] : 24'hEEEEEE;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_pix(input int i);
        logic [WW-1:0] w;
        w = mem[BASE + i / PPW];
        return w[(i % PPW) * PW +: PW];
    endfunction

    // Reference model state and logs
    int          cyc = 0;
    logic        active = 1'b0;
    logic        done_due = 1'b0;
    logic        prev_start = 1'b0;
    int          idx = 0;
    int          nrd = 0;
    int          done_cnt = 0;
    int          last_cnt = 0;
    int          start_cyc = 0;
    int          done_cyc = 0;
    logic [7:0]  stream_q [$];
    logic [AD:0] rd_q [$];
    int          cmd_cyc_q [$];
    int          xfer_cyc_q [$];

    always @(negedge clock) begin
        logic was_done, edge_s;
        cyc++;
        if (!reset) begin
            active = 1'b0; done_due = 1'b0; prev_start = 1'b0; idx = 0; nrd = 0;
            chk("rst_control", 32'(control), 32'd0);
            chk("rst_valid", 32'(pix_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
        end else begin
            chk("busy", 32'(busy), 32'(active));
            chk("done", 32'(done), 32'(done_due));
            if (done) begin done_cnt++; done_cyc = cyc; end
            chk("control_legal", 32'(control != 2'b01), 32'd1);
            if (!active) begin
                chk("idle_control", 32'(control), 32'd0);
                chk("idle_valid", 32'(pix_valid), 32'd0);
            end
            if (control == 2'b10) begin
                chk("rd_addr", 32'(address), 32'(BASE + nrd));
                chk("rd_count_ok", 32'(nrd < NW), 32'd1);
                rd_q.push_back(address);
                cmd_cyc_q.push_back(cyc);
                nrd++;
            end
            if (active && pix_valid) begin
                chk("pix_data", 32'(pix_data), 32'(exp_pix(idx)));
                chk("pix_last", 32'(pix_last), 32'(idx == TOTAL - 1));
            end
            was_done = done_due;
            done_due = 1'b0;
            edge_s   = Start_work_reg[0] && !prev_start;
            if (active && !Start_work_reg[0]) begin
                active = 1'b0;
            end else if (active && pix_valid && pix_ready) begin
                stream_q.push_back(pix_data);
                xfer_cyc_q.push_back(cyc);
                if (pix_last) last_cnt++;
                idx++;
                if (idx == TOTAL) begin active = 1'b0; done_due = 1'b1; end
            end else if (!active && !was_done && edge_s) begin
                active = 1'b1; idx = 0; nrd = 0; start_cyc = cyc;
            end
            prev_start = Start_work_reg[0];
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic set_start(input logic b);
        Start_work_reg = {23'h2A5A5A, b};
    endtask

    task automatic clear_log();
        stream_q.delete(); rd_q.delete(); cmd_cyc_q.delete(); xfer_cyc_q.delete();
        done_cnt = 0; last_cnt = 0;
    endtask

    task automatic wait_pix(input logic [7:0] v, input string nm);
        int n = 0;
        while (!(pix_valid && pix_data == v) && n < 50) begin tick(1); n++; end
        chk({nm, "_reached"}, 32'(pix_valid && pix_data == v), 32'd1);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (done_cnt == 0 && n < 60) begin tick(1); n++; end
        tick(2);
        chk({nm, "_done_pulses"}, 32'(done_cnt), 32'd1);
    endtask

    task automatic check_image(input string nm);
        logic [7:0] exp_stream [6];
        exp_stream = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        chk({nm, "_pix_count"}, 32'(stream_q.size()), 32'd6);
        for (int i = 0; i < stream_q.size() && i < 6; i++)
            chk({nm, "_pix"}, 32'(stream_q[i]), 32'(exp_stream[i]));
        chk({nm, "_rd_count"}, 32'(rd_q.size()), 32'd2);
        if (rd_q.size() == 2) begin
            chk({nm, "_rd_addr0"}, 32'(rd_q[0]), 32'd1);
            chk({nm, "_rd_addr1"}, 32'(rd_q[1]), 32'd2);
        end
        chk({nm, "_last_count"}, 32'(last_cnt), 32'd1);
        chk({nm, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        assert (BASE + NW - 1 < 2 ** AD) else $fatal(1, "address range");
        for (int i = 0; i < 16; i++) mem[i] = 24'hBADBAD;
        mem[0] = 24'h000000;
        mem[1] = 24'h030201;
        mem[2] = 24'h060504;
        reset = 1'b0;
        pix_ready = 1'b1;
        set_start(1'b0);
        tick(2);
        chk("reset_control", 32'(control), 32'd0);
        chk("reset_address", 32'(address), 32'd0);
        chk("reset_pix_data", 32'(pix_data), 32'd0);
        chk("reset_flags", 32'({pix_valid, pix_last, busy, done}), 32'd0);
        reset = 1'b1;
        tick(2);

        // Basic stream with read timing
        clear_log();
        set_start(1'b1);
        wait_done("basic");
        check_image("basic");
        if (cmd_cyc_q.size() >= 1 && xfer_cyc_q.size() == 6) begin
            chk("start_to_cmd", 32'(cmd_cyc_q[0] - start_cyc), 32'd1);
            chk("cmd_to_pix01", 32'(xfer_cyc_q[0] - cmd_cyc_q[0]), 32'd2);
`ifdef PIXEL_FETCHER_PREFETCH_EN
            chk("gap_03_04", 32'(xfer_cyc_q[3] - xfer_cyc_q[2]), 32'd1);
`else
            chk("gap_03_04", 32'(xfer_cyc_q[3] - xfer_cyc_q[2]), 32'd3);
`endif
            chk("done_after_06", 32'(done_cyc - xfer_cyc_q[5]), 32'd1);
        end

        // Start held high through done: no second image
        tick(10);
        chk("no_retrigger_reads", 32'(rd_q.size()), 32'd2);
        chk("no_retrigger_done", 32'(done_cnt), 32'd1);

        // Toggle restarts; backpressure on pixel 02
        clear_log();
        set_start(1'b0);
        tick(1);
        set_start(1'b1);
        wait_pix(8'h02, "bp");
        pix_ready = 1'b0;
        tick(5);
        chk("bp_hold_data", 32'(pix_data), 32'h02);
        chk("bp_hold_valid", 32'(pix_valid), 32'd1);
`ifdef PIXEL_FETCHER_PREFETCH_EN
        chk("bp_reads", 32'(rd_q.size()), 32'd2);
`else
        chk("bp_reads", 32'(rd_q.size()), 32'd1);
`endif
        pix_ready = 1'b1;
        wait_done("bp");
        check_image("bp");

        // Abort after pixel 04, then restart
        set_start(1'b0);
        tick(1);
        clear_log();
        set_start(1'b1);
        wait_pix(8'h04, "abort");
        set_start(1'b0);
        tick(1);
        chk("abort_valid", 32'(pix_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_control", 32'(control), 32'd0);
        tick(5);
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        clear_log();
        set_start(1'b1);
        wait_done("restart");
        check_image("restart");

        // Async reset mid-drain
        set_start(1'b0);
        tick(1);
        set_start(1'b1);
        wait_pix(8'h02, "rst");
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_outputs", 32'({control, pix_valid, pix_last, busy, done}), 32'd0);
        chk("async_rst_data", 32'({pix_data, address}), 32'd0);
        set_start(1'b0);
        tick(3);
        reset = 1'b1;
        clear_log();
        tick(10);
        chk("post_rst_idle_reads", 32'(rd_q.size()), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        set_start(1'b1);
        wait_done("post_rst");
        check_image("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
